// File: rtl/mod_enc_add_round_key.sv
// mod_enc_add_round_key: AES AddRoundKey stage with round counter, block FSM and 2-entry output FIFO
// Ports: clk, reset (async active-low), abort (sync flush);
//   in_state/in_valid/in_ready and key/key_valid/key_ready: joint handshake, both sides move together;
//   key_round: round tag of key, checked only when ARK_ROUNDCHK_EN is defined;
//   round: next round to accept (upstream source select);
//   out_state/out_last/out_valid/out_ready: FIFO head; done: 1-cycle pulse after the last entry pops;
//   err: sticky key/round mismatch flag (tied 0 unless ARK_ROUNDCHK_EN is defined).
module mod_enc_add_round_key #(
  parameter int NR = 14,
  parameter int N = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic abort,
  input  logic [N-1:0][7:0] in_state,
  input  logic in_valid,
  output logic in_ready,
  input  logic [N-1:0][7:0] key,
  input  logic key_valid,
  output logic key_ready,
  input  logic [3:0] key_round,
  output logic [3:0] round,
  output logic [N-1:0][7:0] out_state,
  output logic out_last,
  output logic out_valid,
  input  logic out_ready,
  output logic done,
  output logic err
);
  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;
  state_t state, state_n;
  logic [N-1:0][7:0] mem_d [2];
  logic [1:0] mem_l;
  logic [1:0] count;
  logic rd, wr, round_err, space, xfer, pop, pop_last, is_last;
`ifdef ARK_ROUNDCHK_EN
  assign round_err = key_round != round;
  always_ff @(posedge clk or negedge reset)
    if (!reset) err <= 1'b0;
    else err <= !abort && (err || (in_valid && key_valid && round_err));
`else
  logic unused_key_round;
  assign unused_key_round = ^key_round;
  assign round_err = 1'b0;
  assign err = 1'b0;
`endif
  // readiness of each side looks only at the partner's valid, so no ready/ready loop can form
  assign space = count < 2'd2 && state != DRAIN && !round_err;
  assign in_ready = key_valid && space;
  assign key_ready = in_valid && space;
  assign xfer = in_valid && key_valid && space;
  assign is_last = round == 4'(NR);
  assign out_valid = count != 2'd0;
  assign out_state = out_valid ? mem_d[rd] : '0;
  assign out_last = out_valid && mem_l[rd];
  assign pop = out_valid && out_ready;
  assign pop_last = pop && out_last;
  assign wr = rd ^ count[0];
  always_comb begin
    state_n = abort ? IDLE :
              (xfer && is_last) ? DRAIN :
              (xfer && state == IDLE) ? BUSY :
              (state == DRAIN && pop_last) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      round <= '0;
      count <= '0;
      rd <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      done <= !abort && pop_last;
      if (abort) begin
        round <= '0;
        count <= '0;
        rd <= 1'b0;
      end else begin
        if (xfer) round <= is_last ? '0 : round + 4'd1;
        count <= count + {1'b0, xfer} - {1'b0, pop};
        if (pop) rd <= ~rd;
      end
    end
  // storage needs no reset: the outputs are masked whenever the FIFO is empty
  always_ff @(posedge clk)
    if (xfer) begin
      mem_d[wr] <= in_state ^ key;
      mem_l[wr] <= is_last;
    end
endmodule

// File: tb/tb_mod_enc_add_round_key.sv
// tb_mod_enc_add_round_key: table vectors, directed corner sequences and a queue-model random run
module tb_mod_enc_add_round_key;
  localparam int NR = 14;
  logic clk = 1'b0;
  logic reset, abort, in_valid, key_valid, out_ready;
  logic in_ready, key_ready, out_last, out_valid, done, err;
  logic [15:0][7:0] in_state, key, out_state;
  logic [3:0] key_round, round;
  int checks = 0, failures = 0;
  typedef struct packed {logic [127:0] d; logic l;} ent_t;
  typedef struct {logic [127:0] s; logic [127:0] k; logic [127:0] e;} vec_t;
  ent_t q[$];
  int m_round = 0;
  bit m_drain = 0, m_done = 0, m_err = 0;
  vec_t vecs[4];
  logic [127:0] e1, e2;

  always #5 clk = ~clk;

  mod_enc_add_round_key dut (
    .clk(clk), .reset(reset), .abort(abort),
    .in_state(in_state), .in_valid(in_valid), .in_ready(in_ready),
    .key(key), .key_valid(key_valid), .key_ready(key_ready), .key_round(key_round),
    .round(round), .out_state(out_state), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready), .done(done), .err(err)
  );

  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", n, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference model: a queue of pending outputs plus the block's round position.
  always @(negedge clk) begin
    bit ok_round, acc, popped;
    if (!reset) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_state", out_state, 0);
      q.delete();
      m_round = 0; m_drain = 0; m_done = 0; m_err = 0;
    end else begin
`ifdef ARK_ROUNDCHK_EN
      ok_round = key_round == m_round;
`else
      ok_round = 1;
`endif
      chk("m_round", round, m_round);
      chk("m_out_valid", out_valid, q.size() != 0);
      if (q.size() != 0) begin
        chk("m_out_state", out_state, q[0].d);
        chk("m_out_last", out_last, q[0].l);
      end
      chk("m_done", done, m_done);
      chk("m_err", err, m_err);
      chk("m_in_ready", in_ready, key_valid && q.size() < 2 && !m_drain && ok_round);
      chk("m_key_ready", key_ready, in_valid && q.size() < 2 && !m_drain && ok_round);
      acc = in_valid && key_valid && q.size() < 2 && !m_drain && ok_round;
      popped = q.size() != 0 && out_ready;
      m_done = 0;
      if (abort) begin
        q.delete(); m_round = 0; m_drain = 0; m_err = 0;
      end else begin
`ifdef ARK_ROUNDCHK_EN
        if (in_valid && key_valid && !ok_round) m_err = 1;
`endif
        if (popped) begin
          if (q[0].l) begin m_drain = 0; m_done = 1; end
          void'(q.pop_front());
        end
        if (acc) begin
          q.push_back({in_state ^ key, m_round == NR});
          if (m_round == NR) begin m_round = 0; m_drain = 1; end
          else m_round++;
        end
      end
    end
  end

  task automatic send(input logic [127:0] s, input logic [127:0] k);
    in_state = s; key = k; key_round = round; in_valid = 1; key_valid = 1;
  endtask

  task automatic idle_in();
    in_valid = 0; key_valid = 0;
  endtask

  task automatic do_abort();
    idle_in(); abort = 1; tick(); abort = 0;
  endtask

  initial begin
    vecs[0] = '{128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
                128'h00102030405060708090a0b0c0d0e0f0};
    vecs[1] = '{128'hffffffffffffffffffffffffffffffff, 128'h0, 128'hffffffffffffffffffffffffffffffff};
    vecs[2] = '{128'ha5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5, 128'h5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a,
                128'hffffffffffffffffffffffffffffffff};
    vecs[3] = '{128'h0123456789abcdef0123456789abcdef, 128'h0123456789abcdef0123456789abcdef, 128'h0};
    reset = 0; abort = 0; in_valid = 0; key_valid = 0; out_ready = 0;
    in_state = '0; key = '0; key_round = '0;
    #3;
    chk("reset_round", round, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_done", done, 0);
    chk("reset_err", err, 0);
    tick(); tick();
    reset = 1;
    tick();
    // table vectors, each as a single round-0 transfer followed by abort
    foreach (vecs[i]) begin
      out_ready = 1;
      send(vecs[i].s, vecs[i].k);
      #1 chk("vec_in_ready", in_ready, 1);
      tick();
      idle_in();
      chk("vec_out_state", out_state, vecs[i].e);
      chk("vec_out_last", out_last, 0);
      chk("vec_round", round, 1);
      do_abort();
      chk("vec_abort_valid", out_valid, 0);
      chk("vec_abort_round", round, 0);
      chk("vec_abort_done", done, 0);
    end
    // full block back to back
    out_ready = 1;
    for (int i = 0; i <= NR; i++) begin
      send(rnd128(), rnd128());
      #1 chk("blk_in_ready", in_ready, 1);
      tick();
    end
    in_valid = 0;
    #1;
    chk("blk_drain_ready", in_ready, 0);
    chk("blk_last_valid", out_valid, 1);
    chk("blk_last", out_last, 1);
    chk("blk_round", round, 0);
    key_valid = 0;
    tick();
    chk("blk_done", done, 1);
    chk("blk_empty", out_valid, 0);
    tick();
    chk("blk_done_pulse", done, 0);
    key_valid = 1;
    #1 chk("blk_idle_ready", in_ready, 1);
    key_valid = 0;
    // backpressure: two transfers fill the FIFO, head stays put, then drains in order
    out_ready = 0;
    send(rnd128(), rnd128()); e1 = in_state ^ key;
    #1 chk("bp_ready1", in_ready, 1);
    tick();
    send(rnd128(), rnd128()); e2 = in_state ^ key;
    #1 chk("bp_ready2", in_ready, 1);
    tick();
    send(rnd128(), rnd128());
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_full_ready", in_ready, 0);
      chk("bp_head_stable", out_state, e1);
      tick();
    end
    idle_in(); out_ready = 1;
    #1 chk("bp_drain1", out_state, e1);
    tick();
    chk("bp_drain2", out_state, e2);
    tick();
    chk("bp_drain_empty", out_valid, 0);
    chk("bp_round", round, 2);
    do_abort();
    // abort at round 7 with one entry buffered
    for (int i = 0; i < 7; i++) begin send(rnd128(), rnd128()); tick(); end
    idle_in();
    chk("ab_round7", round, 7);
    chk("ab_buffered", out_valid, 1);
    do_abort();
    chk("ab_valid", out_valid, 0);
    chk("ab_round0", round, 0);
    chk("ab_no_done", done, 0);
    tick();
    chk("ab_no_done2", done, 0);
    send(rnd128(), rnd128()); tick(); idle_in();
    chk("ab_next_round", round, 1);
    chk("ab_next_last", out_last, 0);
    do_abort();
    // round tag check
    for (int i = 0; i < 2; i++) begin send(rnd128(), rnd128()); tick(); end
    send(rnd128(), rnd128()); key_round = 4'd3;
`ifdef ARK_ROUNDCHK_EN
    #1;
    chk("rc_in_ready", in_ready, 0);
    chk("rc_key_ready", key_ready, 0);
    tick();
    chk("rc_err", err, 1);
    chk("rc_round", round, 2);
    idle_in();
    tick();
    chk("rc_err_held", err, 1);
    do_abort();
    chk("rc_err_clear", err, 0);
`else
    #1 chk("rc_ignored", in_ready, 1);
    tick();
    idle_in();
    chk("rc_err_tied", err, 0);
    chk("rc_round", round, 3);
    do_abort();
`endif
    // randomized traffic against the queue model
    for (int c = 0; c < 3000; c++) begin
      in_valid = $urandom_range(0, 3) != 0;
      key_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 2) != 0;
      in_state = rnd128(); key = rnd128();
      key_round = $urandom_range(0, 31) == 0 ? 4'($urandom) : round;
      abort = $urandom_range(0, 99) == 0;
      tick();
    end
    abort = 0;
    do_abort();
    // asynchronous reset while draining
    out_ready = 1;
    for (int i = 0; i <= NR; i++) begin send(rnd128(), rnd128()); tick(); end
    idle_in(); out_ready = 0;
    @(posedge clk);
    #3 reset = 0;
    #1;
    chk("ar_out_valid", out_valid, 0);
    chk("ar_out_state", out_state, 0);
    chk("ar_out_last", out_last, 0);
    chk("ar_round", round, 0);
    chk("ar_done", done, 0);
    chk("ar_err", err, 0);
    tick();
    reset = 1;
    out_ready = 1;
    send(rnd128(), rnd128()); tick(); idle_in();
    chk("ar_first_round", round, 1);
    chk("ar_first_last", out_last, 0);
    tick(); tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
